// File: rtl/value_range_binner.sv
// Streaming value-range histogram: classifies accepted samples into BINS bins with saturating counters.
// Optional sticky per-bin overflow flags are enabled by defining VALUE_RANGE_BINNER_OVERFLOW_FLAG_EN.
module value_range_binner #(
    parameter int WIDTH     = 8,
    parameter int BINS      = 4,
    parameter int CNT_WIDTH = 16,
    parameter int MODE      = 0
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [WIDTH-1:0]            i_data,
    input  logic [(BINS-1)*WIDTH-1:0]   i_thresh,
    input  logic                        i_clear,
    output logic                        o_busy,
    input  logic [$clog2(BINS):0]       i_rd_idx,
    output logic [CNT_WIDTH-1:0]        o_rd_count,
    output logic [CNT_WIDTH-1:0]        o_total
`ifdef VALUE_RANGE_BINNER_OVERFLOW_FLAG_EN
    ,
    output logic [BINS-1:0]             o_ovf
`endif
);

    localparam int                   BIN_W    = $clog2(BINS);
    localparam logic [BIN_W-1:0]     LAST_IDX = BIN_W'(BINS - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    typedef enum logic {
        ST_RUN,
        ST_CLEAR
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [BIN_W-1:0]     r_clr_idx;
    logic                 r_s1_valid;
    logic [BIN_W-1:0]     r_s1_bin;
    logic [CNT_WIDTH-1:0] r_count [BINS];
    logic [CNT_WIDTH-1:0] r_total;
    logic [CNT_WIDTH-1:0] r_rd_count;
    logic [BIN_W-1:0]     w_bin;
    logic                 w_accept;
    logic                 w_inc;

    assign o_ready    = (r_state == ST_RUN);
    assign o_busy     = (r_state == ST_CLEAR);
    assign o_total    = r_total;
    assign o_rd_count = r_rd_count;
    assign w_accept   = i_valid && o_ready;

    generate
        if (MODE == 0) begin : g_split
            logic w_unused_inputs;
            assign w_bin           = i_data[WIDTH-1 -: BIN_W];
            assign w_unused_inputs = ^{i_thresh, i_data};
        end else begin : g_thresh
            // Bin is the number of thresholds at or below the sample, so unordered thresholds still decode.
            always_comb begin
                // NOTE: every always_comb output gets a default first so no latch can be inferred.
                w_bin = '0;
                for (int k = 0; k < BINS - 1; k++) begin
                    if (i_data >= i_thresh[k*WIDTH +: WIDTH]) begin
                        w_bin = w_bin + 1'b1;
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RUN:   if (i_clear) w_next_state = ST_CLEAR;
            ST_CLEAR: if (r_clr_idx == LAST_IDX) w_next_state = ST_RUN;
            default:  w_next_state = ST_RUN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
        if (i_rst) begin
            r_state   <= ST_RUN;
            r_clr_idx <= '0;
        end else begin
            r_state   <= w_next_state;
            r_clr_idx <= (r_state == ST_CLEAR) ? r_clr_idx + 1'b1 : '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_valid <= 1'b0;
            r_s1_bin   <= '0;
        end else begin
            r_s1_valid <= w_accept;
            r_s1_bin   <= w_bin;
        end
    end

    // The stage-1 sample is dropped at the clear edge and throughout the sweep.
    assign w_inc = r_s1_valid && (r_state == ST_RUN) && !i_clear;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: the counter bank is plain flops, so it is reset like any other state.
            for (int b = 0; b < BINS; b++) begin
                r_count[b] <= '0;
            end
            r_total <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_count[r_clr_idx] <= '0;
            if (r_clr_idx == '0) begin
                r_total <= '0;
            end
        end else if (w_inc) begin
            if (r_count[r_s1_bin] != CNT_MAX) begin
                r_count[r_s1_bin] <= r_count[r_s1_bin] + 1'b1;
            end
            if (r_total != CNT_MAX) begin
                r_total <= r_total + 1'b1;
            end
        end
    end

    // BINS is a power of two, so the index MSB alone marks an out-of-range read.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_count <= '0;
        end else if (!i_rd_idx[BIN_W]) begin
            r_rd_count <= r_count[i_rd_idx[BIN_W-1:0]];
        end else begin
            r_rd_count <= '0;
        end
    end

`ifdef VALUE_RANGE_BINNER_OVERFLOW_FLAG_EN
    logic [BINS-1:0] r_ovf;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ovf <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_ovf[r_clr_idx] <= 1'b0;
        end else if (w_inc && (r_count[r_s1_bin] == CNT_MAX)) begin
            r_ovf[r_s1_bin] <= 1'b1;
        end
    end

    assign o_ovf = r_ovf;
`endif

endmodule

// File: tb/tb_value_range_binner.sv
// Scoreboard bench for value_range_binner: equal-split, threshold and 4-bit saturating instances.
module tb_value_range_binner;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] no_thresh = '0;
    logic [23:0] b_thresh;

    logic        a_valid, a_clear, a_ready, a_busy;
    logic [7:0]  a_data;
    logic [2:0]  a_rd_idx;
    logic [15:0] a_rd_count, a_total;

    logic        b_valid, b_clear, b_ready, b_busy;
    logic [7:0]  b_data;
    logic [2:0]  b_rd_idx;
    logic [15:0] b_rd_count, b_total;

    logic        c_valid, c_clear, c_ready, c_busy;
    logic [7:0]  c_data;
    logic [2:0]  c_rd_idx;
    logic [3:0]  c_rd_count, c_total;

`ifdef VALUE_RANGE_BINNER_OVERFLOW_FLAG_EN
    logic [3:0]  a_ovf_unused, b_ovf_unused, c_ovf;
`endif

    int exp_a[4];
    int exp_b[4];
    int exp_c[4];
    int rd_q[$];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    value_range_binner #(.WIDTH(8), .BINS(4), .CNT_WIDTH(16), .MODE(0)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_valid(a_valid), .o_ready(a_ready), .i_data(a_data),
        .i_thresh(no_thresh), .i_clear(a_clear), .o_busy(a_busy), .i_rd_idx(a_rd_idx),
        .o_rd_count(a_rd_count), .o_total(a_total)
`ifdef VALUE_RANGE_BINNER_OVERFLOW_FLAG_EN
        , .o_ovf(a_ovf_unused)
`endif
    );

    value_range_binner #(.WIDTH(8), .BINS(4), .CNT_WIDTH(16), .MODE(1)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_valid(b_valid), .o_ready(b_ready), .i_data(b_data),
        .i_thresh(b_thresh), .i_clear(b_clear), .o_busy(b_busy), .i_rd_idx(b_rd_idx),
        .o_rd_count(b_rd_count), .o_total(b_total)
`ifdef VALUE_RANGE_BINNER_OVERFLOW_FLAG_EN
        , .o_ovf(b_ovf_unused)
`endif
    );

    value_range_binner #(.WIDTH(8), .BINS(4), .CNT_WIDTH(4), .MODE(0)) dut_c (
        .i_clk(clk), .i_rst(rst), .i_valid(c_valid), .o_ready(c_ready), .i_data(c_data),
        .i_thresh(no_thresh), .i_clear(c_clear), .o_busy(c_busy), .i_rd_idx(c_rd_idx),
        .o_rd_count(c_rd_count), .o_total(c_total)
`ifdef VALUE_RANGE_BINNER_OVERFLOW_FLAG_EN
        , .o_ovf(c_ovf)
`endif
    );

    function automatic int split_bin(int d);
        return d / 64;
    endfunction

    function automatic int thresh_bin(int d);
        return int'(d >= 50) + int'(d >= 100) + int'(d >= 150);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", a_ready); end
        n_cmp++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
        n_cmp++; if (a_total !== 16'd0) begin n_err++; $display("FAIL reset_total: got %0d expected 0", a_total); end
        n_cmp++; if (a_rd_count !== 16'd0) begin n_err++; $display("FAIL reset_rd_count: got %0d expected 0", a_rd_count); end
        n_cmp++; if (b_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready_b: got %b expected 1", b_ready); end
    endtask

    task automatic test_equal_split();
        int vals[5] = '{10, 70, 130, 200, 255};
        int want;
        a_rd_idx = 3'd3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a_valid = 1'b1;
            a_data  = 8'(vals[i]);
            exp_a[split_bin(vals[i])]++;
        end
        @(negedge clk);
        a_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (a_rd_count !== 16'd1) begin n_err++; $display("FAIL split_rd_latency_old: got %0d expected 1", a_rd_count); end
        @(negedge clk);
        n_cmp++; if (a_rd_count !== 16'(exp_a[3])) begin n_err++; $display("FAIL split_rd_latency_new: got %0d expected %0d", a_rd_count, exp_a[3]); end
        n_cmp++; if (a_total !== 16'd5) begin n_err++; $display("FAIL split_total: got %0d expected 5", a_total); end
        rd_q.delete();
        for (int i = 0; i <= 5; i++) begin
            @(negedge clk);
            if (i > 0) begin
                want = rd_q.pop_front();
                n_cmp++; if (a_rd_count !== 16'(want)) begin n_err++; $display("FAIL split_count[%0d]: got %0d expected %0d", i - 1, a_rd_count, want); end
            end
            if (i < 5) begin
                a_rd_idx = 3'(i);
                rd_q.push_back(i < 4 ? exp_a[i] : 0);
            end
        end
    endtask

    task automatic test_thresholds();
        int vals[5] = '{49, 50, 99, 150, 0};
        int want;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            b_valid = 1'b1;
            b_data  = 8'(vals[i]);
            exp_b[thresh_bin(vals[i])]++;
        end
        @(negedge clk);
        b_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (b_total !== 16'd5) begin n_err++; $display("FAIL thresh_total: got %0d expected 5", b_total); end
        rd_q.delete();
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                want = rd_q.pop_front();
                n_cmp++; if (b_rd_count !== 16'(want)) begin n_err++; $display("FAIL thresh_count[%0d]: got %0d expected %0d", i - 1, b_rd_count, want); end
            end
            if (i < 4) begin
                b_rd_idx = 3'(i);
                rd_q.push_back(exp_b[i]);
            end
        end
    endtask

    task automatic test_saturation();
        int want;
        int exp_total = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            c_valid = 1'b1;
            c_data  = 8'd5;
            if (exp_c[split_bin(5)] < 15) exp_c[split_bin(5)]++;
            if (exp_total < 15) exp_total++;
        end
        @(negedge clk);
        c_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (c_total !== 4'(exp_total)) begin n_err++; $display("FAIL sat_total: got %0d expected %0d", c_total, exp_total); end
`ifdef VALUE_RANGE_BINNER_OVERFLOW_FLAG_EN
        n_cmp++; if (c_ovf !== 4'b0001) begin n_err++; $display("FAIL sat_ovf: got %b expected 0001", c_ovf); end
`endif
        rd_q.delete();
        for (int i = 0; i <= 2; i++) begin
            @(negedge clk);
            if (i > 0) begin
                want = rd_q.pop_front();
                n_cmp++; if (c_rd_count !== 4'(want)) begin n_err++; $display("FAIL sat_count[%0d]: got %0d expected %0d", i - 1, c_rd_count, want); end
            end
            if (i < 2) begin
                c_rd_idx = 3'(i);
                rd_q.push_back(exp_c[i]);
            end
        end
    endtask

    task automatic test_clear_sweep();
        int want;
        int nbusy = 0;
        @(negedge clk);
        a_valid = 1'b1;
        a_data  = 8'd10;
        @(negedge clk);
        a_data  = 8'd200;
        @(negedge clk);
        a_clear = 1'b1;
        a_data  = 8'd255;
        @(negedge clk);
        a_clear = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (!a_busy) break;
            nbusy++;
            n_cmp++; if (a_ready !== 1'b0) begin n_err++; $display("FAIL clear_ready_low: got %b expected 0", a_ready); end
            if (nbusy >= 4) a_valid = 1'b0;
            @(negedge clk);
        end
        a_valid = 1'b0;
        n_cmp++; if (nbusy != 4) begin n_err++; $display("FAIL clear_busy_cycles: got %0d expected 4", nbusy); end
        n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL clear_ready_back: got %b expected 1", a_ready); end
        n_cmp++; if (a_total !== 16'd0) begin n_err++; $display("FAIL clear_total: got %0d expected 0", a_total); end
        for (int b = 0; b < 4; b++) exp_a[b] = 0;
        rd_q.delete();
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                want = rd_q.pop_front();
                n_cmp++; if (a_rd_count !== 16'(want)) begin n_err++; $display("FAIL clear_count[%0d]: got %0d expected %0d", i - 1, a_rd_count, want); end
            end
            if (i < 4) begin
                a_rd_idx = 3'(i);
                rd_q.push_back(exp_a[i]);
            end
        end
        a_valid = 1'b1;
        a_data  = 8'd130;
        exp_a[split_bin(130)]++;
        @(negedge clk);
        a_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (a_total !== 16'd1) begin n_err++; $display("FAIL post_clear_total: got %0d expected 1", a_total); end
        rd_q.delete();
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                want = rd_q.pop_front();
                n_cmp++; if (a_rd_count !== 16'(want)) begin n_err++; $display("FAIL post_clear_count[%0d]: got %0d expected %0d", i - 1, a_rd_count, want); end
            end
            if (i < 4) begin
                a_rd_idx = 3'(i);
                rd_q.push_back(exp_a[i]);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        int want;
        @(negedge clk);
        a_clear = 1'b1;
        @(negedge clk);
        a_clear = 1'b0;
        n_cmp++; if (a_busy !== 1'b1) begin n_err++; $display("FAIL midrst_busy_before: got %b expected 1", a_busy); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b expected 0", a_busy); end
        n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %b expected 1", a_ready); end
        n_cmp++; if (a_total !== 16'd0) begin n_err++; $display("FAIL midrst_total: got %0d expected 0", a_total); end
        for (int b = 0; b < 4; b++) exp_a[b] = 0;
        rd_q.delete();
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                want = rd_q.pop_front();
                n_cmp++; if (a_rd_count !== 16'(want)) begin n_err++; $display("FAIL midrst_count[%0d]: got %0d expected %0d", i - 1, a_rd_count, want); end
            end
            if (i < 4) begin
                a_rd_idx = 3'(i);
                rd_q.push_back(exp_a[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        b_thresh = {8'd150, 8'd100, 8'd50};
        a_valid = 1'b0; a_clear = 1'b0; a_data = '0; a_rd_idx = '0;
        b_valid = 1'b0; b_clear = 1'b0; b_data = '0; b_rd_idx = '0;
        c_valid = 1'b0; c_clear = 1'b0; c_data = '0; c_rd_idx = '0;
        for (int b = 0; b < 4; b++) begin
            exp_a[b] = 0;
            exp_b[b] = 0;
            exp_c[b] = 0;
        end
        test_reset();
        test_equal_split();
        test_thresholds();
        test_saturation();
        test_clear_sweep();
        test_reset_mid_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/value_range_binner.md
Name: value_range_binner

Overview:
- Streaming histogram block: classifies each accepted sample into one of BINS value ranges and keeps a saturating hit counter per bin.
- Classification is a case/range decode. Equal-split mode uses fixed ranges; threshold mode uses runtime boundaries.
- Sits beside datapath monitors as a statistics collector. Counts are read back through an indexed port and cleared by a sequenced sweep.

Parameters:
- WIDTH, 8, sample width in bits.
- BINS, 4, number of bins; power of two, >= 2.
- CNT_WIDTH, 16, width of each bin counter and of the total counter.
- MODE, 0, classification mode: 0 = equal split by sample MSBs; 1 = runtime thresholds.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  synchronous active-high reset.
- i_valid  input  1  sample valid.
- o_ready  output  1  block can accept a sample.
- i_data  input  WIDTH  sample value.
- i_thresh  input  (BINS-1)*WIDTH  packed ascending thresholds; entry k is the lower bound of bin k+1. Used only when MODE=1.
- i_clear  input  1  one-cycle request to zero all counters.
- o_busy  output  1  clear sweep in progress.
- i_rd_idx  input  $clog2(BINS)+1  readout bin index.
- o_rd_count  output  CNT_WIDTH  registered count of bin i_rd_idx.
- o_total  output  CNT_WIDTH  saturating count of all accepted samples.

Behaviour:
- One clock, i_clk. Synchronous active-high reset, i_rst. All state updates on the rising edge.
- Reset values:
  - all counters 0; o_total 0; o_rd_count 0;
  - o_busy 0; o_ready 1;
  - FSM in RUN; pipeline valid bits 0.
- Accept: a sample is accepted when i_valid && o_ready in the same cycle.
- Classification, MODE=0: bin = i_data[WIDTH-1 -: $clog2(BINS)].
- Classification, MODE=1: bin = count of thresholds k with i_data >= thresh[k], using a priority/case-inside decode.
  - Data below thresh[0] goes to bin 0.
  - Equal thresholds leave the lower bin empty.
  - Non-ascending thresholds give the count-based result; no error is flagged.
- Pipeline, sample accepted at cycle N:
  - stage 1 registers bin index and valid at N+1;
  - stage 2 increments count[bin] and o_total at the N+2 edge;
  - i_rd_idx sampled at cycle N+2 returns the new value on o_rd_count at N+3.
- Back-to-back samples to the same bin each count; there is no read-modify-write hazard.
- Saturation: count[bin] and o_total stop at 2^CNT_WIDTH-1 and never wrap.
- Readout: o_rd_count <= count[i_rd_idx] every cycle. An index >= BINS returns 0.
- FSM states RUN and CLEAR:
  - RUN -> CLEAR when i_clear=1. o_ready drops the next cycle.
  - The stage-1 sample in flight at the clear edge is discarded.
  - In CLEAR, one counter is zeroed per cycle, index 0..BINS-1. o_total is zeroed on the first CLEAR cycle.
  - o_busy=1 and o_ready=0 for exactly BINS cycles, then CLEAR -> RUN.
  - i_clear while in CLEAR is ignored; the sweep does not restart.
- A sample offered in the same cycle as i_clear, with o_ready=1, is accepted but discarded by the clear.
- Reset mid-sweep: all counters zero immediately and the FSM returns to RUN.
- o_ready depends only on the FSM state, never on i_valid.

Optional Feature:
- Macro: VALUE_RANGE_BINNER_OVERFLOW_FLAG_EN.
- When defined:
  - adds output o_ovf [BINS], one sticky bit per bin;
  - the bit sets when an increment is attempted on a saturated counter;
  - bits clear on reset, or per bin as the CLEAR sweep zeroes that bin.
- When undefined: no o_ovf port and no extra flops. Saturation behaviour is identical either way.

Test Plan:
- MODE=0, WIDTH=8, BINS=4; send 10, 70, 130, 200, 255 back-to-back -> counts 1,1,1,2; o_total=5; o_rd_count for idx 3 is 2, three cycles after the last accept.
- MODE=1, thresholds {50,100,150}; send 49, 50, 99, 150, 0 -> counts 2,2,0,1.
- CNT_WIDTH=4; send 20 samples of value 5 -> count[0]=15, o_total=15; o_ovf[0]=1 with the macro defined.
- Accept two samples, then pulse i_clear the cycle after the second accept -> o_busy high 4 cycles; the in-flight sample is dropped; all counts 0; o_ready returns 1; a new sample counts 1.
- Assert i_rst during the 2nd CLEAR cycle -> o_busy=0, o_ready=1, all counts 0 on the next cycle.
- Read i_rd_idx=4 with BINS=4 -> o_rd_count=0; hold i_valid=1 with o_ready=0 during a sweep -> no counter changes.
